lsu: RTL and testbench
======================

Name: lsu

Overview:
- Per-thread load/store unit: one instance per thread in a compute core.
- Responder to the core scheduler. It watches `core_state` and reports progress on `lsu_state`, which the scheduler polls in WAIT.
- Initiator toward the data-memory controller over a valid/ready read channel and a valid/ready write channel.
- Executes at most one LDR or STR per instruction.

Parameters:
- DATA_MEM_ADDR_BITS, 8, width of the data-memory address.
- DATA_MEM_DATA_BITS, 8, width of the data-memory word and register values.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- enable  in  1  thread active in this block; 0 = thread unused.
- core_state  in  3  scheduler state; REQUEST=3'b011, UPDATE=3'b110.
- decoded_mem_read_enable  in  1  current instruction is LDR.
- decoded_mem_write_enable  in  1  current instruction is STR.
- rs  in  DATA_MEM_DATA_BITS  address operand.
- rt  in  DATA_MEM_DATA_BITS  store data operand.
- mem_read_valid  out  1  read request valid.
- mem_read_address  out  DATA_MEM_ADDR_BITS  read address.
- mem_read_ready  in  1  read complete; mem_read_data valid this cycle.
- mem_read_data  in  DATA_MEM_DATA_BITS  read data.
- mem_write_valid  out  1  write request valid.
- mem_write_address  out  DATA_MEM_ADDR_BITS  write address.
- mem_write_data  out  DATA_MEM_DATA_BITS  write data.
- mem_write_ready  in  1  write accepted.
- lsu_state  out  2  IDLE=00, REQUESTING=01, WAITING=10, DONE=11.
- lsu_out  out  DATA_MEM_DATA_BITS  last loaded value, held until the next load.

Behaviour:
- Reset (reset==0 at an edge): lsu_state=IDLE; all mem_* outputs = 0; lsu_out = 0. Reset applies in any state and aborts an in-flight request; valid drops at that edge.
- enable==0: stay IDLE, outputs unchanged. enable is sampled only in IDLE; deasserting it mid-operation has no effect until the unit returns to IDLE.
- IDLE:
  - If core_state==REQUEST and decoded_mem_read_enable → REQUESTING (read op latched).
  - Else if core_state==REQUEST and decoded_mem_write_enable → REQUESTING (write op latched).
  - If both enables are set, the read wins and the write is ignored.
  - Other core_state values: stay IDLE.
- REQUESTING (one cycle):
  - Read: mem_read_valid<=1, mem_read_address<=rs.
  - Write: mem_write_valid<=1, mem_write_address<=rs, mem_write_data<=rt.
  - Next state is WAITING.
  - Operands are captured at this edge; later changes to rs/rt are ignored.
- WAITING:
  - Valid and address/data are held stable until ready is sampled high.
  - Read, mem_read_ready==1: mem_read_valid<=0, lsu_out<=mem_read_data, → DONE.
  - Write, mem_write_ready==1: mem_write_valid<=0, → DONE; lsu_out unchanged.
  - Ready for the channel not in use is ignored. Ready while not WAITING is ignored.
  - No timeout: the unit waits indefinitely.
- DONE: hold until core_state==UPDATE, then → IDLE.
- Latency: REQUEST sampled at edge N → lsu_state=REQUESTING after N → valid high after N+1.
  - Ready sampled high at edge M (M ≥ N+2) → lsu_state=DONE and valid low after M.
  - Minimum request-to-DONE: 3 edges.
- Scheduler contract: lsu_state ∈ {01,10} means busy; {00,11} means not busy. An instruction with no memory access leaves the unit IDLE throughout.
- At most one of mem_read_valid / mem_write_valid is high at any time.
- Address = rs[DATA_MEM_ADDR_BITS-1:0] (truncated, or zero-extended if wider); no arithmetic.

Test Plan:
- Load, single-cycle memory: enable=1, LDR, rs=8'h10, ready+data=8'hA5 in first WAITING cycle → valid high exactly one cycle, address=10, lsu_out=A5, lsu_state 00→01→10→11, →00 on UPDATE.
- Store with back-pressure: STR, rs=8'h20, rt=8'h3C, ready held low 5 cycles → mem_write_valid/address=20/data=3C stable all 6 cycles; lsu_out unchanged; DONE after ready.
- Disabled thread: enable=0, LDR with REQUEST → lsu_state stays 00, no valid ever asserted.
- Both enables set: rs=8'h05 → only mem_read_valid asserts; mem_write_valid stays 0.
- Reset mid-WAITING: drive reset=0 while the read is pending → next edge lsu_state=00, mem_read_valid=0, lsu_out=0; a stray ready afterwards has no effect.
- Operand change and back-to-back: change rs after REQUESTING → address unchanged; second LDR after UPDATE, rs=8'h11, data=8'h7E → lsu_out goes A5→7E only on the second ready.

Source files
------------

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - data-memory read/write channel between the load/store unit and the memory controller
interface lsu_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
);
  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;
  logic                 mem_write_valid;
  logic [ADDR_BITS-1:0] mem_write_address;
  logic [DATA_BITS-1:0] mem_write_data;
  logic                 mem_write_ready;

  modport master (
    output mem_read_valid, mem_read_address,
    input  mem_read_ready, mem_read_data,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_write_ready
  );

  modport slave (
    input  mem_read_valid, mem_read_address,
    output mem_read_ready, mem_read_data,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_write_ready
  );
endinterface

// File: rtl/lsu.sv
// rtl/lsu.sv - per-thread load/store unit issuing one LDR or STR per instruction to data memory
module lsu #(
  parameter int DATA_MEM_ADDR_BITS = 8,
  parameter int DATA_MEM_DATA_BITS = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [2:0]                    core_state,
  input  logic                          decoded_mem_read_enable,
  input  logic                          decoded_mem_write_enable,
  input  logic [DATA_MEM_DATA_BITS-1:0] rs,
  input  logic [DATA_MEM_DATA_BITS-1:0] rt,
  lsu_if.master                         mem,
  output logic [1:0]                    lsu_state,
  output logic [DATA_MEM_DATA_BITS-1:0] lsu_out
);
  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    REQUESTING = 2'b01,
    WAITING    = 2'b10,
    DONE       = 2'b11
  } state_t;

  state_t state, state_next;
  logic   op_read, op_read_next;
  logic   read_valid, read_valid_next;
  logic   write_valid, write_valid_next;
  logic [DATA_MEM_ADDR_BITS-1:0] read_address, read_address_next;
  logic [DATA_MEM_ADDR_BITS-1:0] write_address, write_address_next;
  logic [DATA_MEM_DATA_BITS-1:0] write_data, write_data_next;
  logic [DATA_MEM_DATA_BITS-1:0] out, out_next;
  logic [DATA_MEM_ADDR_BITS-1:0] rs_addr;

  // rs is used as the address verbatim: truncated or zero-extended, never offset
  generate
    if (DATA_MEM_ADDR_BITS <= DATA_MEM_DATA_BITS) begin : g_addr_trunc
      assign rs_addr = rs[DATA_MEM_ADDR_BITS-1:0];
    end else begin : g_addr_zext
      assign rs_addr = {{(DATA_MEM_ADDR_BITS-DATA_MEM_DATA_BITS){1'b0}}, rs};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      op_read       <= 1'b0;
      read_valid    <= 1'b0;
      write_valid   <= 1'b0;
      read_address  <= '0;
      write_address <= '0;
      write_data    <= '0;
      out           <= '0;
    end else begin
      state         <= state_next;
      op_read       <= op_read_next;
      read_valid    <= read_valid_next;
      write_valid   <= write_valid_next;
      read_address  <= read_address_next;
      write_address <= write_address_next;
      write_data    <= write_data_next;
      out           <= out_next;
    end
  end

  always_comb begin
    state_next         = state;
    op_read_next       = op_read;
    read_valid_next    = read_valid;
    write_valid_next   = write_valid;
    read_address_next  = read_address;
    write_address_next = write_address;
    write_data_next    = write_data;
    out_next           = out;
    case (state)
      IDLE: begin
        // read takes priority when a decode flags both
        if (enable && core_state == CORE_REQUEST) begin
          if (decoded_mem_read_enable) begin
            op_read_next = 1'b1;
            state_next   = REQUESTING;
          end else if (decoded_mem_write_enable) begin
            op_read_next = 1'b0;
            state_next   = REQUESTING;
          end
        end
      end
      REQUESTING: begin
        if (op_read) begin
          read_valid_next   = 1'b1;
          read_address_next = rs_addr;
        end else begin
          write_valid_next   = 1'b1;
          write_address_next = rs_addr;
          write_data_next    = rt;
        end
        state_next = WAITING;
      end
      WAITING: begin
        if (op_read) begin
          if (mem.mem_read_ready) begin
            read_valid_next = 1'b0;
            out_next        = mem.mem_read_data;
            state_next      = DONE;
          end
        end else if (mem.mem_write_ready) begin
          write_valid_next = 1'b0;
          state_next       = DONE;
        end
      end
      DONE: begin
        if (core_state == CORE_UPDATE) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem.mem_read_valid    = read_valid;
  assign mem.mem_read_address  = read_address;
  assign mem.mem_write_valid   = write_valid;
  assign mem.mem_write_address = write_address;
  assign mem.mem_write_data    = write_data;
  assign lsu_state             = state;
  assign lsu_out               = out;
endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking bench for the load/store unit
module tb_lsu;
  logic       clk;
  logic       reset;
  logic       enable;
  logic [2:0] core_state;
  logic       rd_en;
  logic       wr_en;
  logic [7:0] rs;
  logic [7:0] rt;
  logic [1:0] lsu_state;
  logic [7:0] lsu_out;
  int total;
  int bad;

  lsu_if #(.ADDR_BITS(8), .DATA_BITS(8)) mem ();

  lsu #(.DATA_MEM_ADDR_BITS(8), .DATA_MEM_DATA_BITS(8)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .enable                   (enable),
    .core_state               (core_state),
    .decoded_mem_read_enable  (rd_en),
    .decoded_mem_write_enable (wr_en),
    .rs                       (rs),
    .rt                       (rt),
    .mem                      (mem),
    .lsu_state                (lsu_state),
    .lsu_out                  (lsu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    enable = 1'b0;
    core_state = 3'b000;
    rd_en = 1'b0;
    wr_en = 1'b0;
    rs = 8'h00;
    rt = 8'h00;
    mem.mem_read_ready  = 1'b0;
    mem.mem_read_data   = 8'h00;
    mem.mem_write_ready = 1'b0;
    tick();
    tick();
    chk("rst_state", lsu_state, 2'b00);
    chk("rst_rvalid", mem.mem_read_valid, 1'b0);
    chk("rst_wvalid", mem.mem_write_valid, 1'b0);
    chk("rst_raddr", mem.mem_read_address, 8'h00);
    chk("rst_waddr", mem.mem_write_address, 8'h00);
    chk("rst_wdata", mem.mem_write_data, 8'h00);
    chk("rst_out", lsu_out, 8'h00);
    reset = 1'b1;

    // load with single-cycle memory
    enable = 1'b1; rd_en = 1'b1; rs = 8'h10; core_state = 3'b011;
    tick();
    chk("ld_req_state", lsu_state, 2'b01);
    chk("ld_req_rvalid", mem.mem_read_valid, 1'b0);
    core_state = 3'b100;
    tick();
    chk("ld_wait_state", lsu_state, 2'b10);
    chk("ld_wait_rvalid", mem.mem_read_valid, 1'b1);
    chk("ld_wait_raddr", mem.mem_read_address, 8'h10);
    chk("ld_wait_wvalid", mem.mem_write_valid, 1'b0);
    mem.mem_read_ready = 1'b1; mem.mem_read_data = 8'hA5;
    tick();
    mem.mem_read_ready = 1'b0; mem.mem_read_data = 8'h00;
    chk("ld_done_state", lsu_state, 2'b11);
    chk("ld_done_rvalid", mem.mem_read_valid, 1'b0);
    chk("ld_done_out", lsu_out, 8'hA5);
    tick();
    chk("ld_hold_done", lsu_state, 2'b11);
    core_state = 3'b110;
    tick();
    chk("ld_update_idle", lsu_state, 2'b00);
    core_state = 3'b000;

    // store with back-pressure
    rd_en = 1'b0; wr_en = 1'b1; rs = 8'h20; rt = 8'h3C; core_state = 3'b011;
    tick();
    chk("st_req_state", lsu_state, 2'b01);
    core_state = 3'b100;
    tick();
    rs = 8'hEE; rt = 8'hDD;
    for (int i = 0; i < 6; i++) begin
      chk("st_bp_state", lsu_state, 2'b10);
      chk("st_bp_wvalid", mem.mem_write_valid, 1'b1);
      chk("st_bp_waddr", mem.mem_write_address, 8'h20);
      chk("st_bp_wdata", mem.mem_write_data, 8'h3C);
      chk("st_bp_rvalid", mem.mem_read_valid, 1'b0);
      if (i < 5) begin
        mem.mem_read_ready = 1'b1;
        tick();
        mem.mem_read_ready = 1'b0;
      end
    end
    mem.mem_write_ready = 1'b1;
    tick();
    mem.mem_write_ready = 1'b0;
    chk("st_done_state", lsu_state, 2'b11);
    chk("st_done_wvalid", mem.mem_write_valid, 1'b0);
    chk("st_done_out", lsu_out, 8'hA5);
    core_state = 3'b110;
    tick();
    chk("st_update_idle", lsu_state, 2'b00);
    core_state = 3'b000; wr_en = 1'b0;

    // disabled thread
    enable = 1'b0; rd_en = 1'b1; rs = 8'h44; core_state = 3'b011;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dis_state", lsu_state, 2'b00);
      chk("dis_rvalid", mem.mem_read_valid, 1'b0);
    end
    core_state = 3'b000; enable = 1'b1;

    // both decode enables set: read wins
    rd_en = 1'b1; wr_en = 1'b1; rs = 8'h05; rt = 8'h77; core_state = 3'b011;
    tick();
    chk("both_req_state", lsu_state, 2'b01);
    core_state = 3'b100;
    tick();
    chk("both_rvalid", mem.mem_read_valid, 1'b1);
    chk("both_wvalid", mem.mem_write_valid, 1'b0);
    chk("both_raddr", mem.mem_read_address, 8'h05);
    mem.mem_write_ready = 1'b1;
    tick();
    mem.mem_write_ready = 1'b0;
    chk("both_wready_ignored", lsu_state, 2'b10);
    mem.mem_read_ready = 1'b1; mem.mem_read_data = 8'h5A;
    tick();
    mem.mem_read_ready = 1'b0;
    chk("both_done_state", lsu_state, 2'b11);
    chk("both_done_out", lsu_out, 8'h5A);
    chk("both_done_wvalid", mem.mem_write_valid, 1'b0);
    core_state = 3'b110;
    tick();
    core_state = 3'b000; wr_en = 1'b0;

    // reset while a read is pending
    rs = 8'h33; core_state = 3'b011;
    tick();
    core_state = 3'b100;
    tick();
    chk("rstw_pending", mem.mem_read_valid, 1'b1);
    reset = 1'b0;
    tick();
    chk("rstw_state", lsu_state, 2'b00);
    chk("rstw_rvalid", mem.mem_read_valid, 1'b0);
    chk("rstw_raddr", mem.mem_read_address, 8'h00);
    chk("rstw_out", lsu_out, 8'h00);
    reset = 1'b1; core_state = 3'b000;
    mem.mem_read_ready = 1'b1; mem.mem_read_data = 8'hFF;
    tick();
    mem.mem_read_ready = 1'b0;
    chk("stray_state", lsu_state, 2'b00);
    chk("stray_out", lsu_out, 8'h00);

    // operand change after capture, then back-to-back loads
    rs = 8'h10; core_state = 3'b011;
    tick();
    core_state = 3'b100;
    tick();
    rs = 8'h99;
    tick();
    chk("opchg_raddr", mem.mem_read_address, 8'h10);
    mem.mem_read_ready = 1'b1; mem.mem_read_data = 8'hA5;
    tick();
    mem.mem_read_ready = 1'b0;
    chk("b2b_first_out", lsu_out, 8'hA5);
    core_state = 3'b110;
    tick();
    chk("b2b_idle", lsu_state, 2'b00);
    rs = 8'h11; core_state = 3'b011;
    tick();
    core_state = 3'b100;
    tick();
    chk("b2b_raddr", mem.mem_read_address, 8'h11);
    mem.mem_read_data = 8'h7E;
    tick();
    chk("b2b_out_held", lsu_out, 8'hA5);
    mem.mem_read_ready = 1'b1;
    tick();
    mem.mem_read_ready = 1'b0;
    chk("b2b_second_out", lsu_out, 8'h7E);
    chk("b2b_second_state", lsu_state, 2'b11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
